// File: rtl/booth8_pkg.sv
// Shared definitions for the radix-8 Booth multiplier family.
//   - state_e     : controller states (IDLE, RUN, DONE)
//   - sel_e       : one-hot multiple select {ZERO, X1, X2, X3, X4}
//   - digit_sel_t : select plus negate flag for one recoded digit
//   - booth8_decode() : maps a 4-bit recoding window to a digit_sel_t
package booth8_pkg;

    localparam int unsigned N_DIGITS   = 11; // 33-bit sign-extended multiplier / 3
    localparam int unsigned DIGIT_BITS = 4;  // window b[3i+2:3i-1]
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    typedef enum logic [4:0] {
        ZERO = 5'b00001,
        X1   = 5'b00010,
        X2   = 5'b00100,
        X3   = 5'b01000,
        X4   = 5'b10000
    } sel_e;

    typedef struct packed {
        sel_e sel;
        logic neg;
    } digit_sel_t;

    // d = -4*r[3] + 2*r[2] + r[1] + r[0]
    function automatic digit_sel_t booth8_decode(input logic [DIGIT_BITS-1:0] r);
        logic [2:0] pos;
        logic [2:0] mag;
        digit_sel_t ds;
        pos = {1'b0, r[2], 1'b0} + {2'b00, r[1]} + {2'b00, r[0]};
        // With r[3] set the digit is pos-4, so its magnitude is 4-pos.
        mag = r[3] ? (3'd4 - pos) : pos;
        ds.neg = r[3] && (pos != 3'd4);
        case (mag)
            3'd0:    ds.sel = ZERO;
            3'd1:    ds.sel = X1;
            3'd2:    ds.sel = X2;
            3'd3:    ds.sel = X3;
            default: ds.sel = X4;
        endcase
        return ds;
    endfunction

endpackage

// File: rtl/booth8_digit_select.sv
// Combinational radix-8 Booth partial-product selector.
// Ports:
//   bits [3:0] : recoding window b[3i+2:3i-1]
//   m1..m4     : registered multiples A, 2A, 3A, 4A (64-bit, sign-extended)
//   pp         : signed partial product for this digit, not yet shifted
module booth8_digit_select
    import booth8_pkg::*;
(
    input  logic [DIGIT_BITS-1:0] bits,
    input  logic [63:0]           m1,
    input  logic [63:0]           m2,
    input  logic [63:0]           m3,
    input  logic [63:0]           m4,
    output logic [63:0]           pp
);

    digit_sel_t ds;
    logic [63:0] mag;

    always_comb begin
        ds  = booth8_decode(bits);
        mag = '0;
        unique case (ds.sel)
            ZERO:    mag = '0;
            X1:      mag = m1;
            X2:      mag = m2;
            X3:      mag = m3;
            X4:      mag = m4;
            default: mag = '0;
        endcase
        pp = ds.neg ? (64'd0 - mag) : mag;
    end

endmodule

// File: rtl/booth8_seq_mul.sv
// Sequential signed 32x32 radix-8 Booth multiplier, one digit per cycle.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, tri_a = 3a, b)
//   out_valid / out_ready: product handshake
//   product              : signed 64-bit a*b
// Optional build macro BOOTH8_APPROX_TRUNC_EN: skip the APPROX_DIGITS low digits,
// giving a*(b - b_low) with APPROX_DIGITS fewer cycles of latency.
module booth8_seq_mul
    import booth8_pkg::*;
#(
    parameter int unsigned APPROX_DIGITS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [33:0] tri_a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] product
);

`ifdef BOOTH8_APPROX_TRUNC_EN
    localparam int unsigned FIRST = APPROX_DIGITS;
`else
    // Exact build: every digit is accumulated, APPROX_DIGITS has no effect.
    localparam int unsigned FIRST = APPROX_DIGITS * 0;
`endif

    localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(FIRST);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(N_DIGITS - 1);

    state_e           state;
    logic [63:0]      m1, m2, m3, m4;
    logic [33:0]      b_ext;
    logic [63:0]      acc;
    logic [CNT_W-1:0] cnt;

    logic [5:0]            shamt;
    logic [DIGIT_BITS-1:0] window;
    logic [63:0]           pp;
    logic [63:0]           acc_next;

    assign in_ready = (state == IDLE);

    // Digit i sits at bit 3i of b_ext, which is also its weight 8^i.
    assign shamt    = {2'b00, cnt} * 6'd3;
    assign window   = b_ext[shamt +: DIGIT_BITS];
    assign acc_next = acc + (pp << shamt);

    booth8_digit_select u_sel (
        .bits (window),
        .m1   (m1),
        .m2   (m2),
        .m3   (m3),
        .m4   (m4),
        .pp   (pp)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            product   <= '0;
            acc       <= '0;
            cnt       <= '0;
            m1        <= '0;
            m2        <= '0;
            m3        <= '0;
            m4        <= '0;
            b_ext     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        m1    <= {{32{a[31]}}, a};
                        m2    <= {{31{a[31]}}, a, 1'b0};
                        m3    <= {{30{tri_a[33]}}, tri_a};
                        m4    <= {{30{a[31]}}, a, 2'b00};
                        b_ext <= {b[31], b, 1'b0};
                        acc   <= '0;
                        cnt   <= CNT_FIRST;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        product   <= acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth8_seq_mul.sv
// Self-checking bench for booth8_seq_mul: directed vectors, latency, backpressure,
// mid-run reset, back-to-back operations and a short exact-mode random sweep.
module tb_booth8_seq_mul;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [33:0] tri_a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;

    int errors = 0;
    int checks = 0;

`ifdef BOOTH8_APPROX_TRUNC_EN
    localparam int LAT = 10;
    localparam logic [63:0] EXP_M7X6 = 64'h0; // b=6 lies entirely in skipped digits
`else
    localparam int LAT = 12;
    localparam logic [63:0] EXP_M7X6 = 64'hFFFF_FFFF_FFFF_FFD6;
`endif

    booth8_seq_mul dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .tri_a     (tri_a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    function automatic logic [33:0] tri3(input logic [31:0] x);
        logic signed [33:0] sx;
        sx = {{2{x[31]}}, x};
        return 34'(sx * 34'sd3);
    endfunction

    // Drives one operand set, returns the product and the edge count from the accept
    // edge (counted as 1) to out_valid high. Consumes the result if out_ready is high.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                         output logic [63:0] p, output int lat);
        int n;
        a = av;
        b = bv;
        tri_a = tri3(av);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        p = product;
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                            input logic [63:0] exp_p);
        logic [63:0] p;
        int lat;
        do_op(av, bv, p, lat);
        checks++;
        if (p !== exp_p) begin
            errors++;
            $display("FAIL %s product: got %h expected %h", name, p, exp_p);
        end
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, LAT);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        tri_a = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (product !== 64'h0) begin
            errors++;
            $display("FAIL reset product: got %h expected 0", product);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

`ifdef BOOTH8_APPROX_TRUNC_EN
    task automatic test_approx();
        check_op("approx_3x5",    32'd3,          32'd5,    64'h0);
        check_op("approx_3x64",   32'd3,          32'd64,   64'd192);
        // 1000 = 1024 + (-24): the low six bits read as -24 are dropped
        check_op("approx_m1x1000", 32'hFFFF_FFFF, 32'd1000, 64'hFFFF_FFFF_FFFF_FC00);
    endtask
`else
    task automatic test_exact();
        check_op("3x5",       32'd3,          32'd5,          64'h0000_0000_0000_000F);
        check_op("min_x_min", 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000);
        check_op("max_x_max", 32'h7FFF_FFFF,  32'h7FFF_FFFF,  64'h3FFF_FFFF_0000_0001);
        check_op("m1x1",      32'hFFFF_FFFF,  32'd1,          64'hFFFF_FFFF_FFFF_FFFF);
        check_op("m5xm3",     32'hFFFF_FFFB,  32'hFFFF_FFFD,  64'h0000_0000_0000_000F);
        check_op("12345xm1",  32'd12345,      32'hFFFF_FFFF,  64'hFFFF_FFFF_FFFF_CFC7);
        check_op("0x0",       32'd0,          32'd0,          64'h0);
    endtask

    task automatic test_random();
        logic [31:0] av, bv;
        logic [63:0] p, exp_p;
        int lat;
        int bad = 0;
        for (int i = 0; i < 300; i++) begin
            av = $urandom;
            bv = $urandom;
            exp_p = 64'($signed({{32{av[31]}}, av}) * $signed({{32{bv[31]}}, bv}));
            do_op(av, bv, p, lat);
            checks++;
            if (p !== exp_p || lat !== LAT) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random a=%h b=%h: got %h lat %0d expected %h lat %0d",
                             av, bv, p, lat, exp_p, LAT);
            end
        end
    endtask
`endif

    task automatic test_backpressure();
        logic [63:0] p;
        int lat;
        logic unstable = 1'b0;
        logic accepted = 1'b0;
        out_ready = 1'b0;
        do_op(32'd3, 32'd64, p, lat);
        checks++;
        if (p !== 64'd192 || lat !== LAT) begin
            errors++;
            $display("FAIL bp_first: got %h lat %0d expected %h lat %0d", p, lat, 64'd192, LAT);
        end
        a = 32'd7;
        b = 32'd7;
        tri_a = tri3(32'd7);
        in_valid = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (product !== 64'd192 || out_valid !== 1'b1) unstable = 1'b1;
            if (in_ready !== 1'b0) accepted = 1'b1;
        end
        checks++;
        if (unstable) begin
            errors++;
            $display("FAIL bp_stall_hold: got product %h valid %b expected %h valid 1",
                     product, out_valid, 64'd192);
        end
        checks++;
        if (accepted) begin
            errors++;
            $display("FAIL bp_in_ready: got in_ready high during stall expected 0");
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got valid %b ready %b expected valid 0 ready 1",
                     out_valid, in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_not_latched: got ready %b valid %b expected ready 1 valid 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        a = 32'd5;
        b = 32'd9;
        tri_a = tri3(32'd5);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 64'h0) begin
            errors++;
            $display("FAIL midrun_reset: got valid %b ready %b product %h expected 0 1 0",
                     out_valid, in_ready, product);
        end
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrun_abort: got out_valid %b expected 0", out_valid);
        end
        check_op("after_reset_m7x6", 32'hFFFF_FFF9, 32'd6, EXP_M7X6);
    endtask

    task automatic test_back_to_back();
        check_op("b2b_first",  32'd3, 32'd64, 64'd192);
        check_op("b2b_second", 32'hFFFF_FFFF, 32'd1 << 12, 64'hFFFF_FFFF_FFFF_F000);
    endtask

    initial begin
        test_reset();
`ifdef BOOTH8_APPROX_TRUNC_EN
        test_approx();
`else
        test_exact();
        test_random();
`endif
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
